mcse_ami_egress: RTL and testbench

Downstream consumer of the MCSE top-level AMI output. Accepts 256-bit result words from the MCSE with a valid/ack handshake and buffers them in a small FIFO. Serializes each word into eight 32-bit beats on a valid/ready stream toward the AMI fabric, marking the last beat. It also keeps a running count of words delivered.

---
 rtl/mcse_ami_pkg.sv | 22 ++
 rtl/mcse_ami_fifo.sv | 58 +++++
 rtl/mcse_ami_egress.sv | 102 ++++++++++
 tb/tb_mcse_ami_egress.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcse_ami_pkg.sv
// MCSE AMI egress shared definitions.
// Word/beat geometry and serializer state, shared with mcse_top-side logic.
package mcse_ami_pkg;

   localparam int AMI_WORD_W = 256;
   localparam int AMI_BEAT_W = 32;
   localparam int AMI_BEATS  = 8;
   localparam int AMI_BIDX_W = $clog2(AMI_BEATS);

   typedef enum logic {
      IDLE,
      STREAM
   } ser_state_t;

   function automatic logic [AMI_BEAT_W-1:0] beat_sel(
      input logic [AMI_WORD_W-1:0] w,
      input logic [AMI_BIDX_W-1:0] b
   );
      return w[AMI_BEAT_W*b +: AMI_BEAT_W];
   endfunction

endpackage

// File: rtl/mcse_ami_fifo.sv
// MCSE AMI word buffer.
// Synchronous FIFO, async active-low reset, head is read combinationally.
module mcse_ami_fifo
   import mcse_ami_pkg::*;
#(
   parameter int W     = AMI_WORD_W,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] data_in,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty,
   output logic         one_left
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push_ok;
   logic          pop_ok;

   assign push_ok  = push & ~full;
   assign pop_ok   = pop & ~empty;
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign one_left = (count == (AW+1)'(1));
   assign head     = mem[rd_ptr];

   // Storage array: written on accepted pushes only.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= data_in;
   end

   // Pointers and occupancy; push and pop together leave count unchanged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mcse_ami_egress.sv
// MCSE AMI egress: captures 256-bit words, streams them as 8 x 32-bit beats.
// Optional MCSE_AMI_PARITY_EN adds an even-parity output per beat.
module mcse_ami_egress
   import mcse_ami_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [AMI_WORD_W-1:0] ami_in,
   input  logic                  ami_valid,
   output logic                  ami_ack,
   output logic [AMI_BEAT_W-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic [CNT_W-1:0]      words_sent,
   output logic                  fifo_full
`ifdef MCSE_AMI_PARITY_EN
  ,output logic                  out_parity
`endif
);

   localparam logic [AMI_BIDX_W-1:0] LAST_B = AMI_BIDX_W'(AMI_BEATS-1);

   ser_state_t            state;
   ser_state_t            state_nxt;
   logic [AMI_BIDX_W-1:0] b;
   logic [AMI_WORD_W-1:0] head;
   logic                  empty;
   logic                  one_left;
   logic                  push;
   logic                  hs;
   logic                  last_hs;

   // Ack low qualifier blocks a second capture while MCSE reacts to ack.
   assign push    = ami_valid & ~fifo_full & ~ami_ack;
   assign hs      = out_valid & out_ready;
   assign last_hs = hs & (b == LAST_B);

   mcse_ami_fifo #(
      .W     (AMI_WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (last_hs),
      .data_in  (ami_in),
      .head     (head),
      .full     (fifo_full),
      .empty    (empty),
      .one_left (one_left)
   );

   // Capture acknowledge: one-cycle pulse after each accepted word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ami_ack <= 1'b0;
      else      ami_ack <= push;
   end

   // Serializer state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next state: leave STREAM only when the final pop empties the buffer.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:   if (!empty) state_nxt = STREAM;
         STREAM: if (last_hs && one_left && !push) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Beat index advances on each handshake, wrapping to 0 after beat 7.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    b <= '0;
      else if (hs) b <= b + 1'b1;
   end

   // Delivered-word counter, free-running wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         words_sent <= '0;
      else if (last_hs) words_sent <= words_sent + 1'b1;
   end

   // Outputs derived from registers only; data forced to 0 when idle.
   always_comb begin
      out_valid = (state == STREAM);
      out_last  = out_valid & (b == LAST_B);
      out_data  = '0;
      if (out_valid) out_data = beat_sel(head, b);
`ifdef MCSE_AMI_PARITY_EN
      out_parity = ^out_data;
`endif
   end

endmodule

// File: tb/tb_mcse_ami_egress.sv
// Randomized bench for mcse_ami_egress against a queue-based word/beat model.
// Honors MCSE_AMI_PARITY_EN when defined.
module tb_mcse_ami_egress;

   localparam int DEPTH = 2;
   localparam int CW    = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [255:0] ami_in = '0;
   logic         ami_valid = 1'b0;
   logic         ami_ack;
   logic [31:0]  out_data;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic         out_last;
   logic [CW-1:0] words_sent;
   logic         fifo_full;
`ifdef MCSE_AMI_PARITY_EN
   logic         out_parity;
`endif

   mcse_ami_egress #(
      .FIFO_DEPTH (DEPTH),
      .CNT_W      (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ami_in     (ami_in),
      .ami_valid  (ami_valid),
      .ami_ack    (ami_ack),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .words_sent (words_sent),
      .fifo_full  (fifo_full)
`ifdef MCSE_AMI_PARITY_EN
     ,.out_parity (out_parity)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   // model: words held in buffer, current beat, words delivered
   logic [255:0] q[$];
   int mb = 0;
   int delivered = 0;
   int acks = 0;
   bit ma = 0;
   bit mv = 0;

   // driver controls
   int offer = 0;
   int rmode = 0;
   bit gappy = 0;
   bit directed = 0;
   logic [255:0] dword;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_data();
      logic [255:0] w;
      if (!mv || q.size() == 0) return 32'h0;
      w = q[0];
      return w[mb*32 +: 32];
   endfunction

   task automatic check_outputs();
      logic [31:0] ed;
      ed = exp_data();
      chk("ack", 64'(ami_ack), 64'(ma));
      chk("valid", 64'(out_valid), 64'(mv));
      chk("last", 64'(out_last), 64'(mv && mb == 7));
      chk("data", 64'(out_data), 64'(ed));
      chk("full", 64'(fifo_full), 64'(q.size() == DEPTH));
      chk("count", 64'(words_sent), 64'(delivered % (1 << CW)));
`ifdef MCSE_AMI_PARITY_EN
      chk("parity", 64'(out_parity), 64'(^ed));
`endif
   endtask

   task automatic drive();
      if (ami_valid && ma) ami_valid = 1'b0;
      if (!ami_valid && offer > 0 &&
          (!gappy || $urandom_range(0, 2) == 0)) begin
         ami_valid = 1'b1;
         if (directed) ami_in = dword;
         else ami_in = {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom};
         offer--;
      end
      case (rmode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         2:       out_ready = ~out_ready;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   // one clock: update model from pre-edge inputs, check, drive next inputs
   task automatic step();
      bit push;
      int occ0;
      @(posedge clk);
      occ0 = q.size();
      push = ami_valid && !ma && occ0 < DEPTH;
      if (mv && out_ready) begin
         if (mb == 7) begin
            void'(q.pop_front());
            delivered++;
            mb = 0;
         end else begin
            mb++;
         end
      end
      if (push) begin
         q.push_back(ami_in);
         acks++;
      end
      ma = push;
      mv = (q.size() > 0) && (occ0 > 0);
      #1;
      check_outputs();
      drive();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      rmode = 1;
      while ((q.size() != 0 || ami_valid || offer != 0 || mv) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) chk("drain_timeout", 64'd1, 64'd0);
   endtask

   initial begin
      int a0;
      int d0;
      int n;
      for (int k = 0; k < 8; k++) dword[k*32 +: 32] = 32'(k + 1);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
      rst = 1'b1;

      // single word, known beat pattern
      directed = 1;
      offer = 1;
      rmode = 1;
      step();
      drain(40);
      chk("single_cnt", 64'(words_sent), 64'd1);

      // back-pressure, ready toggling
      directed = 0;
      offer = 1;
      rmode = 2;
      repeat (20) step();
      drain(40);

      // full: three words offered, ready low
      a0 = acks;
      d0 = delivered;
      offer = 3;
      rmode = 0;
      repeat (12) step();
      chk("full_acks", 64'(acks - a0), 64'd2);
      chk("full_flag", 64'(fifo_full), 64'd1);
      rmode = 1;
      n = 0;
      while (acks - a0 < 3 && n < 40) begin
         step();
         n++;
      end
      chk("third_ack_after_pop", 64'(delivered - d0), 64'd1);
      drain(60);

      // counter wrap over five words
      d0 = delivered;
      offer = 5;
      drain(100);
      chk("wrap5", 64'(words_sent), 64'((d0 + 5) % (1 << CW)));

      // randomized traffic
      gappy = 1;
      offer = 150;
      rmode = 3;
      n = 0;
      while (offer > 0 && n < 4000) begin
         step();
         n++;
      end
      gappy = 0;
      drain(200);

      // parity examples on directed beats
      for (int k = 0; k < 8; k++) dword[k*32 +: 32] = 32'(k);
      directed = 1;
      offer = 1;
      drain(40);

      // reset mid-stream with another word buffered
      directed = 0;
      offer = 2;
      rmode = 0;
      n = 0;
      while (q.size() < 2 && n < 20) begin
         step();
         n++;
      end
      chk("pre_reset_fill", 64'(q.size()), 64'd2);
      rmode = 1;
      n = 0;
      while (!(mv && mb == 3) && n < 20) begin
         step();
         n++;
      end
      chk("pre_reset_beat", 64'(mb), 64'd3);
      #2;
      rst = 1'b0;
      ami_valid = 1'b0;
      offer = 0;
      q.delete();
      mb = 0;
      delivered = 0;
      ma = 0;
      mv = 0;
      #1;
      check_outputs();
      #3;
      rst = 1'b1;
      repeat (15) step();
      chk("post_reset_idle", 64'(out_valid), 64'd0);

      // fresh word after reset
      offer = 1;
      drain(40);
      chk("post_reset_cnt", 64'(words_sent), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end

endmodule
